// File: rtl/bus_memory.sv
// Nibble-wide CPU memory with a small memory-mapped I/O window and a streaming
// program loader that takes ownership of the RAM while load_mode is held.
module bus_memory #(
  parameter int          RAM_DEPTH = 256,
  parameter logic [11:0] IO_BASE   = 12'hFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] bus_addr,
  input  logic        bus_we,
  input  logic [3:0]  bus_wdata,
  output logic [3:0]  bus_rdata,
  output logic        cpu_hold,
  input  logic        load_mode,
  input  logic        load_valid,
  input  logic [3:0]  load_data,
  output logic        load_ready,
  output logic        load_overflow,
  output logic [15:0] out_port,
  input  logic [3:0]  in_port
);

  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(RAM_DEPTH - 1);

  typedef enum logic {
    SERVE = 1'b0,
    LOAD  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [3:0]    r_ram [RAM_DEPTH];
  logic [3:0]    r_rdata;
  logic [15:0]   r_outPort;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [AW-1:0] r_loadPtr;
  logic          r_overflow;

  logic [11:0]   w_ioOff;
  logic          w_isRam;
  logic          w_isOut;
  logic          w_isIn;
  logic [AW-1:0] w_ramIdx;
  logic [3:0]    w_readData;
  logic          w_enterLoad;
  logic          w_serveWrite;
  logic          w_loadAccept;

  always_comb begin
    w_nextState = SERVE;
    if (load_mode) begin
      w_nextState = LOAD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SERVE;
    end else begin
      r_state <= w_nextState;
    end
  end

  assign w_enterLoad  = (r_state == SERVE) && load_mode;
  assign w_serveWrite = (r_state == SERVE) && bus_we;
  assign w_loadAccept = (r_state == LOAD) && load_valid;

  assign w_ioOff  = bus_addr - IO_BASE;
  assign w_isRam  = int'({20'd0, bus_addr}) < RAM_DEPTH;
  assign w_isOut  = (bus_addr >= IO_BASE) && (w_ioOff < 12'd4);
  assign w_isIn   = (bus_addr == (IO_BASE + 12'd8));
  assign w_ramIdx = bus_addr[AW-1:0];

  always_comb begin
    w_readData = 4'h0;
    if (w_isRam) begin
      w_readData = r_ram[w_ramIdx];
    end else if (w_isOut) begin
      w_readData = r_outPort[{w_ioOff[1:0], 2'b00} +: 4];
    end else if (w_isIn) begin
      w_readData = r_sync2;
    end
  end

  // RAM deliberately has no reset so a reset mid-load keeps already loaded words.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_loadAccept) begin
        r_ram[r_loadPtr] <= load_data;
      end else if (w_serveWrite && w_isRam) begin
        r_ram[w_ramIdx] <= bus_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata   <= 4'h0;
      r_outPort <= 16'h0000;
    end else if (r_state == LOAD) begin
      r_rdata <= 4'h0;
    end else if (bus_we) begin
      if (w_isOut) begin
        r_outPort[{w_ioOff[1:0], 2'b00} +: 4] <= bus_wdata;
      end
    end else begin
      r_rdata <= w_readData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 4'h0;
      r_sync2 <= 4'h0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_loadPtr  <= '0;
      r_overflow <= 1'b0;
    end else if (w_enterLoad) begin
      r_loadPtr  <= '0;
      r_overflow <= 1'b0;
    end else if (w_loadAccept) begin
      if (r_loadPtr == LAST_PTR) begin
        r_loadPtr  <= '0;
        r_overflow <= 1'b1;
      end else begin
        r_loadPtr <= r_loadPtr + 1'b1;
      end
    end
  end

  assign bus_rdata     = (r_state == LOAD) ? 4'h0 : r_rdata;
  assign cpu_hold      = (r_state == LOAD);
  assign load_ready    = (r_state == LOAD);
  assign load_overflow = r_overflow;
  assign out_port      = r_outPort;

endmodule
